// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic {
        REQ_CPU,
        REQ_AUX
    } req_id_t;

    localparam int unsigned DEFAULT_MAX_BURST = 4;
    localparam int unsigned STARVE_CNT_W      = 4;

endpackage : data_mem_arb_pkg

// File: rtl/data_mem_arbiter_starve.sv
// Saturating starvation counter for the auxiliary requester.
// force_aux is raised once the count reaches LIMIT; hold freezes the count.
module arb_starve_cnt
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic force_aux
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: hold beats clear beats increment; saturate at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_aux = (cnt_q == LIMIT_C);

endmodule : arb_starve_cnt

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Requester 0 (CPU) has fixed priority; requester 1 (aux) is guaranteed a slot
// after MAX_BURST consecutive CPU grants. Read data returns one cycle later.
// Optional macro DATA_MEM_ARB_LOCK_EN adds lock0 for atomic CPU sequences.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DATA_MEM_ARB_LOCK_EN
    input  logic                 lock0,
`endif
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [DATA_SIZE-1:0] wdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DATA_SIZE-1:0] rdata0,
    output logic [DATA_SIZE-1:0] rdata1,
    output logic                 mem_w,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);

    logic                 force_aux;
    logic                 lock_hold;
    logic                 gnt_any;
    req_id_t              sel;
    logic                 rvalid0_q, rvalid1_q;
    logic [DATA_SIZE-1:0] rdata0_q, rdata1_q;

`ifdef DATA_MEM_ARB_LOCK_EN
    assign lock_hold = req0 && lock0;
`else
    assign lock_hold = 1'b0;
`endif

    arb_starve_cnt #(
        .LIMIT (MAX_BURST)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (gnt0 && req1),
        .clr       (gnt1 || !req1),
        .hold      (lock_hold),
        .force_aux (force_aux)
    );

    // Grant selection: aux wins when alone or when forced (and not locked out).
    always_comb begin
        gnt_any = 1'b0;
        sel     = REQ_CPU;
        if (!rst) begin
            if (req1 && (!req0 || (force_aux && !lock_hold))) begin
                gnt_any = 1'b1;
                sel     = REQ_AUX;
            end else if (req0) begin
                gnt_any = 1'b1;
                sel     = REQ_CPU;
            end
        end
    end

    assign gnt0 = gnt_any && (sel == REQ_CPU);
    assign gnt1 = gnt_any && (sel == REQ_AUX);

    // Memory port mux: granted requester drives the memory, otherwise all zero.
    always_comb begin
        mem_w     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_w     = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_w     = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // Read response registers: one-cycle valid pulse, data held until next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 && !we0;
            rvalid1_q <= gnt1 && !we1;
            if (gnt0 && !we0) begin
                rdata0_q <= mem_rdata;
            end
            if (gnt1 && !we1) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule : data_mem_arbiter

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a read-data scoreboard per requester.
// Build with DATA_MEM_ARB_LOCK_EN defined to also exercise lock0.
module tb_data_mem_arbiter;

    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_w;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
`ifdef DATA_MEM_ARB_LOCK_EN
    logic       lock0 = 1'b0;
`endif

    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0, last1;
    logic       mon_en = 1'b0;
    int         total = 0;
    int         bad = 0;
    int unsigned mc = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_SIZE (8),
        .ADDR_SIZE (5),
        .MAX_BURST (MB)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DATA_MEM_ARB_LOCK_EN
        .lock0     (lock0),
`endif
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_w     (mem_w),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port memory: combinational read, posedge write.
    always @(posedge clk) begin
        if (mem_w) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: each scoreboard entry must appear exactly one cycle after accept.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() > 0) begin
                last0 = q0.pop_front();
                chk("rvalid0", 32'(rvalid0), 32'd1);
            end else begin
                chk("rvalid0", 32'(rvalid0), 32'd0);
            end
            chk("rdata0", 32'(rdata0), 32'(last0));
            if (q1.size() > 0) begin
                last1 = q1.pop_front();
                chk("rvalid1", 32'(rvalid1), 32'd1);
            end else begin
                chk("rvalid1", 32'(rvalid1), 32'd0);
            end
            chk("rdata1", 32'(rdata1), 32'(last1));
        end
    end

    // One directed cycle: called at posedge+1, returns at next posedge+1.
    task automatic step(input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1,
                        input logic eg0, input logic eg1, input string tag);
        logic       ew;
        logic [4:0] ea;
        logic [7:0] ed;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        ew = eg0 ? w0 : (eg1 ? w1 : 1'b0);
        ea = eg0 ? a0 : (eg1 ? a1 : 5'd0);
        ed = eg0 ? d0 : (eg1 ? d1 : 8'd0);
        @(negedge clk);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
        chk({tag, ".mem_w"}, 32'(mem_w), 32'(ew));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(ed));
        @(posedge clk);
        if (eg0 && !w0) q0.push_back(ref_mem[a0]);
        if (eg1 && !w1) q1.push_back(ref_mem[a1]);
        if (eg0 && w0) ref_mem[a0] = d0;
        if (eg1 && w1) ref_mem[a1] = d1;
        #1;
    endtask

    initial begin
        logic eg1;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        last0 = '0; last1 = '0;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd1; wdata0 = 8'hFF;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #2;
        chk("rst.gnt0", 32'(gnt0), 32'd0);
        chk("rst.mem_w", 32'(mem_w), 32'd0);
        chk("rst.rvalid0", 32'(rvalid0), 32'd0);
        chk("rst.rdata1", 32'(rdata1), 32'd0);
        chk("rst.starve", 32'(u_dut.u_starve.cnt_q), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single read by aux, then back-to-back CPU reads (addr 1 untouched by reset write).
        step(0, 0, 0, 0, 1, 0, 5'd3, 0, 0, 1, "rd1");
        step(1, 0, 5'd1, 0, 0, 0, 0, 0, 1, 0, "b2b_a");
        step(1, 0, 5'd2, 0, 0, 0, 0, 0, 1, 0, "b2b_b");
        step(1, 0, 5'd4, 0, 0, 0, 0, 0, 1, 0, "b2b_c");

        // Write then read of the same address from the other requester.
        step(1, 1, 5'd7, 8'hA5, 0, 0, 0, 0, 1, 0, "wr7");
        step(0, 0, 0, 0, 1, 0, 5'd7, 0, 0, 1, "rd7");
        step(0, 0, 0, 0, 1, 1, 5'd9, 8'h3C, 0, 1, "wr9_aux");
        step(1, 0, 5'd9, 0, 0, 0, 0, 0, 1, 0, "rd9_cpu");

        // Idle cycles: no grant, counter stays cleared.
        step(0, 0, 5'd6, 8'h11, 0, 0, 5'd8, 8'h22, 0, 0, "idle_a");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_b");
        chk("idle.starve", 32'(u_dut.u_starve.cnt_q), 32'd0);

        // Contention: both requesters held, expected pattern from a counter model.
        mc = 0;
        for (int i = 0; i < 12; i++) begin
            chk("cont.starve", 32'(u_dut.u_starve.cnt_q), 32'(mc));
            eg1 = (mc == MB);
            step(1, 0, 5'(i), 0, 1, 0, 5'(20 + i), 0, !eg1, eg1, "cont");
            mc = eg1 ? 0 : ((mc < MB) ? mc + 1 : mc);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "cont_end");
        mc = 0;

`ifdef DATA_MEM_ARB_LOCK_EN
        // Locked CPU burst: aux starves and counter holds; forcing resumes after unlock.
        lock0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 5'd2, 0, 1, 0, 5'd3, 0, 1, 0, "lock");
        end
        chk("lock.starve", 32'(u_dut.u_starve.cnt_q), 32'd0);
        lock0 = 1'b0;
        for (int i = 0; i <= int'(MB); i++) begin
            eg1 = (mc == MB);
            step(1, 0, 5'd2, 0, 1, 0, 5'd3, 0, !eg1, eg1, "unlock");
            mc = eg1 ? 0 : mc + 1;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "unlock_end");
`endif

        // Reset mid-read: response dropped at once; write during reset is discarded.
        step(1, 0, 5'd2, 0, 0, 0, 0, 0, 1, 0, "rst_rd");
        rst = 1'b1;
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0;
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 5'd5; wdata1 = 8'hEE;
        #1;
        chk("arst.rvalid0", 32'(rvalid0), 32'd0);
        chk("arst.rdata0", 32'(rdata0), 32'd0);
        chk("arst.gnt1", 32'(gnt1), 32'd0);
        chk("arst.mem_w", 32'(mem_w), 32'd0);
        @(posedge clk);
        #1;
        chk("arst.starve", 32'(u_dut.u_starve.cnt_q), 32'd0);
        rst = 1'b0;
        step(0, 0, 0, 0, 1, 0, 5'd5, 0, 0, 1, "rst_rb");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain_a");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain_b");

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_mem_arbiter
